// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host transmitter and the keyboard receive path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5,
    ERR       = 3'd6
  } ps2_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NO_CLK  = 2'b01;
  localparam logic [1:0] ERR_XFER_TO = 2'b10;
  localparam logic [1:0] ERR_NO_ACK  = 2'b11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // PS/2 frames carry odd parity over the data byte.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the PS/2 pads, debounces the clock and flags filtered falling edges.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_filt,
  output logic o_data_sync,
  output logic o_fall
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  logic          r_clk_filt;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Two-flop sync, then accept a clock level only after FILTER_LEN equal samples.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_filt  <= 1'b1;
      r_fall      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      r_fall      <= 1'b0;
      if (r_clk_sync[1] == r_clk_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_clk_filt <= r_clk_sync[1];
        r_cnt      <= '0;
        r_fall     <= r_clk_filt;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_clk_filt  = r_clk_filt;
  assign o_data_sync = r_data_sync[1];
  assign o_fall      = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-clock frame, ACK check, timeouts.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC  = 12000,
  parameter int unsigned START_TO_CYC = 1500000,
  parameter int unsigned XFER_TO_CYC  = 200000,
  parameter int unsigned FILTER_LEN   = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_tx_done,
  output logic       o_tx_err,
  output logic [1:0] o_err_code,
  output logic       o_rx_inhibit,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_data_in,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe
);

  localparam int unsigned TW = $clog2(START_TO_CYC + 1);

  ps2_state_t    r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [3:0]    r_bitcnt, w_bitcnt_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_parity, w_parity_nxt;
  logic [1:0]    r_err_code, w_err_code_nxt;
  logic          r_tx_ready, r_tx_done, r_tx_err, r_rx_inhibit, r_clk_oe, r_data_oe;
  logic          w_tx_done_nxt, w_clk_oe_nxt, w_data_oe_nxt, w_bit_oe;
  logic          w_clk_filt, w_data_sync, w_fall;
  logic          w_start_to, w_xfer_to;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_ps2_clk   (i_ps2_clk_in),
    .i_ps2_data  (i_ps2_data_in),
    .o_clk_filt  (w_clk_filt),
    .o_data_sync (w_data_sync),
    .o_fall      (w_fall)
  );

  assign w_start_to = (r_timer > TW'(START_TO_CYC));
  assign w_xfer_to  = (r_timer > TW'(XFER_TO_CYC));

  // State, datapath and registered outputs; reset drops both pad enables at once.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_bitcnt     <= '0;
      r_data       <= '0;
      r_parity     <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_tx_ready   <= 1'b1;
      r_tx_done    <= 1'b0;
      r_tx_err     <= 1'b0;
      r_rx_inhibit <= 1'b0;
      r_clk_oe     <= 1'b0;
      r_data_oe    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_data       <= w_data_nxt;
      r_parity     <= w_parity_nxt;
      r_err_code   <= w_err_code_nxt;
      r_tx_ready   <= (w_state_nxt == IDLE);
      r_tx_done    <= w_tx_done_nxt;
      r_tx_err     <= (w_state_nxt == ERR);
      r_rx_inhibit <= (w_state_nxt != IDLE);
      r_clk_oe     <= w_clk_oe_nxt;
      r_data_oe    <= w_data_oe_nxt;
    end
  end

  // Next-state, timer and bit sequencing; pad enables derived from the next state.
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer + TW'(1);
    w_bitcnt_nxt   = r_bitcnt;
    w_data_nxt     = r_data;
    w_parity_nxt   = r_parity;
    w_err_code_nxt = r_err_code;
    w_bit_oe       = r_data_oe;
    w_tx_done_nxt  = 1'b0;
    w_clk_oe_nxt   = 1'b0;
    w_data_oe_nxt  = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_timer_nxt = '0;
        if (i_tx_valid && r_tx_ready) begin
          w_data_nxt     = i_tx_data;
          w_parity_nxt   = odd_parity(i_tx_data);
          w_err_code_nxt = ERR_NONE;
          w_bitcnt_nxt   = '0;
          w_state_nxt    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (r_timer == TW'(INHIBIT_CYC - 1)) begin
          w_state_nxt = START;
          w_timer_nxt = TW'(1);
        end
      end
      START: begin
        if (w_fall) begin
          w_bit_oe     = ~r_data[0];
          w_bitcnt_nxt = 4'd1;
          w_timer_nxt  = TW'(1);
          w_state_nxt  = DATA;
        end else if (w_start_to) begin
          w_err_code_nxt = ERR_NO_CLK;
          w_state_nxt    = ERR;
        end
      end
      DATA: begin
        if (w_fall) begin
          w_bitcnt_nxt = r_bitcnt + 4'd1;
          if (r_bitcnt < 4'd8) begin
            w_bit_oe = ~r_data[r_bitcnt[2:0]];
          end else if (r_bitcnt == 4'd8) begin
            w_bit_oe = ~r_parity;
          end else begin
            w_bit_oe    = 1'b0;
            w_state_nxt = ACK;
          end
        end else if (w_xfer_to) begin
          w_err_code_nxt = ERR_XFER_TO;
          w_state_nxt    = ERR;
        end
      end
      ACK: begin
        if (w_fall) begin
          if (!w_data_sync) begin
            w_state_nxt = WAIT_IDLE;
          end else begin
            w_err_code_nxt = ERR_NO_ACK;
            w_state_nxt    = ERR;
          end
        end else if (w_xfer_to) begin
          w_err_code_nxt = ERR_XFER_TO;
          w_state_nxt    = ERR;
        end
      end
      WAIT_IDLE: begin
        if (w_clk_filt && w_data_sync) begin
          w_state_nxt   = IDLE;
          w_tx_done_nxt = 1'b1;
        end else if (w_xfer_to) begin
          w_err_code_nxt = ERR_XFER_TO;
          w_state_nxt    = ERR;
        end
      end
      ERR: begin
        w_timer_nxt = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_clk_oe_nxt = (w_state_nxt == INHIBIT);
    unique case (w_state_nxt)
      INHIBIT: w_data_oe_nxt = (w_timer_nxt == TW'(INHIBIT_CYC - 1));
      START:   w_data_oe_nxt = 1'b1;
      DATA:    w_data_oe_nxt = w_bit_oe;
      default: w_data_oe_nxt = 1'b0;
    endcase
  end

  assign o_tx_ready    = r_tx_ready;
  assign o_tx_done     = r_tx_done;
  assign o_tx_err      = r_tx_err;
  assign o_err_code    = r_err_code;
  assign o_rx_inhibit  = r_rx_inhibit;
  assign o_ps2_clk_oe  = r_clk_oe;
  assign o_ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: keyboard BFM on open-drain lines, scoreboard queues for frames/events.
module tb_ps2_host_tx;

  localparam int H = 100;  // BFM half period in system clocks
  localparam logic [1:0] EV_NONE = 2'b00;
  localparam logic [1:0] EV_DONE = 2'b10;
  localparam logic [1:0] EV_ERR  = 2'b01;

  typedef struct {
    logic [1:0] kind;
    logic [1:0] code;
  } ev_t;

  typedef struct {
    logic [7:0] cmd;
    logic       ack_high;
    int         glitch_at;
    logic [1:0] exp_kind;
    logic [1:0] exp_code;
  } vec_t;

  logic       clk, i_rst, i_tx_valid;
  logic [7:0] i_tx_data;
  logic       o_tx_ready, o_tx_done, o_tx_err, o_rx_inhibit, o_ps2_clk_oe, o_ps2_data_oe;
  logic [1:0] o_err_code;
  logic       bfm_clk_low, bfm_data_low, glitch_low;
  logic       ps2_clk_line, ps2_data_line;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int inh_run = 0;
  ev_t         exp_ev_q[$];
  int          exp_inh_q[$];
  logic [7:0]  exp_frame_q[$];
  ev_t         mon_e;
  vec_t        vec[6];

  assign ps2_clk_line  = !(o_ps2_clk_oe || bfm_clk_low || glitch_low);
  assign ps2_data_line = !(o_ps2_data_oe || bfm_data_low);

  ps2_host_tx #(
    .INHIBIT_CYC (100),
    .START_TO_CYC(5000),
    .XFER_TO_CYC (3000),
    .FILTER_LEN  (8)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_tx_valid   (i_tx_valid),
    .i_tx_data    (i_tx_data),
    .o_tx_ready   (o_tx_ready),
    .o_tx_done    (o_tx_done),
    .o_tx_err     (o_tx_err),
    .o_err_code   (o_err_code),
    .o_rx_inhibit (o_rx_inhibit),
    .i_ps2_clk_in (ps2_clk_line),
    .i_ps2_data_in(ps2_data_line),
    .o_ps2_clk_oe (o_ps2_clk_oe),
    .o_ps2_data_oe(o_ps2_data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic model_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2) == 0;
  endfunction

  // Length of each clock-inhibit pulse against the queued expectation.
  always @(negedge clk) begin
    if (o_ps2_clk_oe) begin
      inh_run++;
    end else if (inh_run != 0) begin
      if (exp_inh_q.size() == 0) chk("unexpected_inhibit", 32'(inh_run), 32'd0);
      else chk("inhibit_len", 32'(inh_run), 32'(exp_inh_q.pop_front()));
      inh_run = 0;
    end
  end

  // Done/error pulses against the queued expectation.
  always @(negedge clk) begin
    if (o_tx_done || o_tx_err) begin
      if (exp_ev_q.size() == 0) begin
        chk("unexpected_event", 32'({o_tx_done, o_tx_err}), 32'(EV_NONE));
      end else begin
        mon_e = exp_ev_q.pop_front();
        chk("event_kind", 32'({o_tx_done, o_tx_err}), 32'(mon_e.kind));
        chk("event_err_code", 32'(o_err_code), 32'(mon_e.code));
      end
    end
  end

  task automatic start_tx(input logic [7:0] b, input logic [1:0] kind, input logic [1:0] code,
                          input bit push_frame);
    int n = 0;
    ev_t e;
    @(negedge clk);
    while (!o_tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("ready_timeout", 32'(o_tx_ready), 32'd1);
    i_tx_valid = 1'b1;
    i_tx_data  = b;
    exp_inh_q.push_back(100);
    if (kind != EV_NONE) begin
      e.kind = kind;
      e.code = code;
      exp_ev_q.push_back(e);
    end
    if (push_frame) exp_frame_q.push_back(b);
    @(posedge clk);
    #1;
    i_tx_valid = 1'b0;
  endtask

  task automatic drain_events(input int budget);
    int n = 0;
    while (exp_ev_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("event_timeout", 32'(exp_ev_q.size()), 32'd0);
  endtask

  // Keyboard side: waits for request-to-send, clocks the frame, samples on rising edges.
  task automatic bfm_frame(input logic ack_high, input int glitch_at, input int stop_after);
    int n = 0;
    logic [10:0] smp;
    logic [7:0] eb;
    smp = '0;
    while (!(ps2_clk_line && !ps2_data_line) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      chk("start_bit_timeout", 32'(ps2_data_line), 32'd0);
      return;
    end
    repeat (50) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (stop_after != 0 && k > stop_after) break;
      bfm_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      bfm_clk_low = 1'b0;
      smp[k-1] = ps2_data_line;
      if (k == glitch_at) begin
        repeat (40) @(negedge clk);
        glitch_low = 1'b1;
        repeat (3) @(negedge clk);
        glitch_low = 1'b0;
        repeat (H - 43) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      if (k == 10) bfm_data_low = !ack_high;
      if (k == 11) bfm_data_low = 1'b0;
    end
    if (stop_after == 0) begin
      if (exp_frame_q.size() == 0) begin
        chk("unexpected_frame", 32'(smp[7:0]), 32'd0);
      end else begin
        eb = exp_frame_q.pop_front();
        chk("frame_data", 32'(smp[7:0]), 32'(eb));
        chk("frame_parity", 32'(smp[8]), 32'(model_parity(eb)));
        chk("frame_stop", 32'(smp[9]), 32'd1);
      end
    end
  endtask

  initial begin
    int n;
    int t0;
    i_rst = 1'b0;
    i_tx_valid = 1'b0;
    i_tx_data = 8'h00;
    bfm_clk_low = 1'b0;
    bfm_data_low = 1'b0;
    glitch_low = 1'b0;

    vec[0] = '{8'hED, 1'b0, 0, EV_DONE, 2'b00};
    vec[1] = '{8'hF4, 1'b0, 0, EV_DONE, 2'b00};
    vec[2] = '{8'h3C, 1'b1, 0, EV_ERR,  2'b11};
    vec[3] = '{8'hF4, 1'b0, 0, EV_DONE, 2'b00};
    vec[4] = '{8'hFF, 1'b0, 0, EV_DONE, 2'b00};
    vec[5] = '{8'h96, 1'b0, 4, EV_DONE, 2'b00};

    repeat (5) @(posedge clk);
    #1;
    chk("reset_tx_ready", 32'(o_tx_ready), 32'd1);
    chk("reset_tx_done", 32'(o_tx_done), 32'd0);
    chk("reset_tx_err", 32'(o_tx_err), 32'd0);
    chk("reset_err_code", 32'(o_err_code), 32'd0);
    chk("reset_rx_inhibit", 32'(o_rx_inhibit), 32'd0);
    chk("reset_oe", 32'({o_ps2_clk_oe, o_ps2_data_oe}), 32'd0);
    @(negedge clk);
    i_rst = 1'b1;

    // Table: normal frames, missing ACK, clock glitch.
    for (int i = 0; i < 6; i++) begin
      start_tx(vec[i].cmd, vec[i].exp_kind, vec[i].exp_code, 1'b1);
      chk("busy_after_accept", 32'({o_tx_ready, o_rx_inhibit}), 32'b01);
      bfm_frame(vec[i].ack_high, vec[i].glitch_at, 0);
      drain_events(1000);
      if (vec[i].exp_kind == EV_ERR) begin
        repeat (5) @(negedge clk);
        chk("err_code_held", 32'(o_err_code), 32'(vec[i].exp_code));
      end
    end

    // No device clock: start timeout measured from clock release.
    start_tx(8'hF4, EV_ERR, 2'b01, 1'b0);
    n = 0;
    while (o_ps2_clk_oe && n < 200) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    n = 0;
    while (!o_tx_err && n < 6000) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if ((cyc - t0) < 4998 || (cyc - t0) > 5002) begin
      n_fail++;
      $display("FAIL noclk_latency: got %0d cycles expected 5000+-2", cyc - t0);
    end
    chk("noclk_oe_released", 32'({o_ps2_clk_oe, o_ps2_data_oe}), 32'd0);
    drain_events(10);

    // Device stops clocking mid-frame: transfer timeout.
    start_tx(8'h12, EV_ERR, 2'b10, 1'b0);
    bfm_frame(1'b0, 0, 3);
    drain_events(5000);

    // Back-to-back: second byte taken in the tx_done cycle, held valid ignored while busy.
    @(negedge clk);
    i_tx_valid = 1'b1;
    i_tx_data = 8'hFF;
    exp_inh_q.push_back(100);
    exp_ev_q.push_back('{EV_DONE, 2'b00});
    exp_frame_q.push_back(8'hFF);
    @(posedge clk);
    #1;
    i_tx_data = 8'hF4;
    exp_inh_q.push_back(100);
    exp_ev_q.push_back('{EV_DONE, 2'b00});
    exp_frame_q.push_back(8'hF4);
    bfm_frame(1'b0, 0, 0);
    n = 0;
    while (!o_tx_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_ready_in_done", 32'({o_tx_done, o_tx_ready}), 32'b11);
    @(posedge clk);
    #1;
    chk("b2b_accepted", 32'({o_tx_ready, o_rx_inhibit}), 32'b01);
    i_tx_valid = 1'b0;
    bfm_frame(1'b0, 0, 0);
    drain_events(1000);

    // Reset while D4 (a zero) is being driven.
    start_tx(8'h0F, EV_NONE, 2'b00, 1'b0);
    bfm_frame(1'b0, 0, 5);
    chk("d4_driven_low", 32'({o_ps2_data_oe, o_rx_inhibit}), 32'b11);
    @(negedge clk);
    #2;
    i_rst = 1'b0;
    #1;
    chk("rst_oe_drop", 32'({o_ps2_clk_oe, o_ps2_data_oe}), 32'd0);
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_after_release", 32'({o_tx_ready, o_rx_inhibit, o_err_code}), 32'b1000);
    repeat (500) @(negedge clk);

    chk("inhibit_q_empty", 32'(exp_inh_q.size()), 32'd0);
    chk("event_q_empty", 32'(exp_ev_q.size()), 32'd0);
    chk("frame_q_empty", 32'(exp_frame_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
